countdown_ctrl: RTL

- Sequencing controller that sits directly upstream of the 4-bit loadable down-counter (count4) and drives its `set`, `set_count` and `dec` inputs.
- It also watches the counter's `count` output, so it closes the loop around the counter.
- On `start` it loads a preset, issues one `dec` pulse every PRESCALE clocks until `count` reaches 0, then pulses `done`.
- It supports pause/resume, restart while running, and guarantees no decrement is ever issued at zero.

---
 rtl/countdown_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/countdown_ctrl.sv
// Sequencer wrapped around a loadable down-counter: loads a preset, paces decrements
// by PRESCALE clocks, supports pause/restart, and pulses done once the count hits zero.
module countdown_ctrl #(
    parameter int PRESCALE = 4,
    parameter int W        = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_pause,
    input  logic [W-1:0] i_preset,
    input  logic [W-1:0] i_count,
    output logic         o_set,
    output logic [W-1:0] o_set_count,
    output logic         o_dec,
    output logic         o_busy,
    output logic         o_done
);

    localparam int PW = $clog2(PRESCALE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_prescaler;
    logic            r_set;
    logic [W-1:0]    r_setCount;
    logic            r_dec;
    logic            r_busy;
    logic            r_done;

    state_t          w_nextState;
    logic [PW-1:0]   w_nextPrescaler;
    logic            w_nextSet;
    logic [W-1:0]    w_nextSetCount;
    logic            w_nextDec;
    logic            w_nextBusy;
    logic            w_nextDone;
    logic            w_lastTick;

    assign w_lastTick = (r_prescaler == PW'(PRESCALE - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_prescaler <= '0;
            r_set       <= 1'b0;
            r_setCount  <= '0;
            r_dec       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_prescaler <= w_nextPrescaler;
            r_set       <= w_nextSet;
            r_setCount  <= w_nextSetCount;
            r_dec       <= w_nextDec;
            r_busy      <= w_nextBusy;
            r_done      <= w_nextDone;
        end
    end

    // Strobes default low each cycle; the zero check precedes the decrement so dec never fires at zero.
    always_comb begin
        w_nextState     = r_state;
        w_nextPrescaler = r_prescaler;
        w_nextSet       = 1'b0;
        w_nextSetCount  = r_setCount;
        w_nextDec       = 1'b0;
        w_nextBusy      = r_busy;
        w_nextDone      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nextState    = S_LOAD;
                    w_nextSet      = 1'b1;
                    w_nextSetCount = i_preset;
                    w_nextBusy     = 1'b1;
                end
            end

            S_LOAD: begin
                w_nextState     = S_RUN;
                w_nextPrescaler = '0;
            end

            S_RUN, S_PAUSED: begin
                if (i_start) begin
                    w_nextState    = S_LOAD;
                    w_nextSet      = 1'b1;
                    w_nextSetCount = i_preset;
                end else if (i_pause) begin
                    w_nextState = S_PAUSED;
                end else if (i_count == '0) begin
                    w_nextState = S_DONE;
                    w_nextDone  = 1'b1;
                    w_nextBusy  = 1'b0;
                end else begin
                    w_nextState = S_RUN;
                    if (w_lastTick) begin
                        w_nextDec       = 1'b1;
                        w_nextPrescaler = '0;
                    end else begin
                        w_nextPrescaler = r_prescaler + PW'(1);
                    end
                end
            end

            S_DONE: begin
                w_nextState = S_IDLE;
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign o_set       = r_set;
    assign o_set_count = r_setCount;
    assign o_dec       = r_dec;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
